hcsr04_echo_model: RTL and testbench

//  Synthesizable responder model of the HC-SR04 ultrasonic sensor: the far end of the trig/echo protocol.

---
 rtl/hcsr04_echo_model.sv | 146 ++++++++++++++
 tb/tb_hcsr04_echo_model.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hcsr04_echo_model.sv
// HC-SR04 responder: accepts a trig pulse and answers with an echo whose width encodes distance_mm.
// Used as the far end of the trig/echo link for loopback and self-test of the sensor controller.
module hcsr04_echo_model #(
  parameter int unsigned MIN_TRIG_CYC = 1000,
  parameter int unsigned BURST_CYC    = 20000,
  parameter int unsigned CYC_PER_MM   = 588,
  parameter int unsigned MAX_MM       = 4000,
  parameter int unsigned TIMEOUT_CYC  = 3800000,
  parameter int unsigned HOLDOFF_CYC  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [11:0] distance_mm,
  output logic        echo,
  output logic        busy,
  output logic        short_trig
);

  localparam int unsigned CNT_W  = 22;
  localparam int unsigned DIST_W = 12;
  localparam int unsigned CPM_W  = 10;

  localparam logic [CNT_W-1:0]  MIN_TRIG_C = CNT_W'(MIN_TRIG_CYC);
  localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST_CYC - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [DIST_W-1:0] MAX_D      = DIST_W'(MAX_MM);
  localparam logic [CPM_W-1:0]  CPM        = CPM_W'(CYC_PER_MM);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG_HI = 3'd1,
    S_BURST   = 3'd2,
    S_ECHO    = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] echo_len, echo_len_n;
  logic             echo_n, short_n;
  logic             trig_meta, trig_s, trig_d;
  logic             trig_rise;
  logic             dist_ok;
  logic [CNT_W-1:0] dist_prod;

  // 2-FF synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
      trig_d    <= 1'b0;
    end else begin
      trig_meta <= trig;
      trig_s    <= trig_meta;
      trig_d    <= trig_s;
    end
  end

  assign trig_rise = trig_s & ~trig_d;
  assign dist_ok   = (distance_mm != '0) && (distance_mm <= MAX_D);
  assign dist_prod = CNT_W'(distance_mm) * CNT_W'(CPM);

  // state register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      echo_len   <= '0;
      echo       <= 1'b0;
      busy       <= 1'b0;
      short_trig <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      echo_len   <= echo_len_n;
      echo       <= echo_n;
      busy       <= (state_n != S_IDLE);
      short_trig <= short_n;
    end
  end

  // one shared counter serves as width, burst, echo and holdoff timer
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    echo_len_n = echo_len;
    echo_n     = 1'b0;
    short_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig_rise) begin
          state_n = S_TRIG_HI;
          cnt_n   = CNT_ONE;
        end
      end
      S_TRIG_HI: begin
        if (trig_s) begin
          if (cnt != CNT_MAX) cnt_n = cnt + CNT_ONE;
        end else if (cnt >= MIN_TRIG_C) begin
          state_n    = S_BURST;
          cnt_n      = '0;
          echo_len_n = dist_ok ? dist_prod : TIMEOUT_C;
        end else begin
          state_n = S_IDLE;
          cnt_n   = '0;
          short_n = 1'b1;
        end
      end
      S_BURST: begin
        if (cnt == BURST_LAST) begin
          state_n = S_ECHO;
          cnt_n   = '0;
          echo_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_ECHO: begin
        if (cnt == echo_len - CNT_ONE) begin
          state_n = S_HOLDOFF;
          cnt_n   = '0;
        end else begin
          cnt_n  = cnt + CNT_ONE;
          echo_n = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_hcsr04_echo_model.sv
// Scoreboard bench for hcsr04_echo_model with scaled-down timing parameters.
// Stimulus predicts echo/short_trig events from the protocol rules; a monitor pops and compares.
module tb_hcsr04_echo_model;

  localparam int unsigned MIN_TRIG = 20;
  localparam int unsigned BURST    = 50;
  localparam int unsigned CPMM     = 2;
  localparam int unsigned MAXMM    = 150;
  localparam int unsigned TIMEOUT  = 500;
  localparam int unsigned HOLDOFF  = 60;

  logic        clk;
  logic        rst;
  logic        trig;
  logic [11:0] distance_mm;
  logic        echo, busy, short_trig;

  hcsr04_echo_model #(
    .MIN_TRIG_CYC(MIN_TRIG), .BURST_CYC(BURST), .CYC_PER_MM(CPMM),
    .MAX_MM(MAXMM), .TIMEOUT_CYC(TIMEOUT), .HOLDOFF_CYC(HOLDOFF)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .distance_mm(distance_mm),
    .echo(echo), .busy(busy), .short_trig(short_trig)
  );

  typedef struct {
    bit          is_echo;
    int unsigned at;
    int unsigned width;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned model_idle = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
  endtask

  function automatic int unsigned ref_len(input int unsigned d);
    if (d == 0 || d > MAXMM) return TIMEOUT;
    return d * CPMM;
  endfunction

  // trig high for w cycles; predicts the DUT response if it should be idle when the edge lands
  task automatic send(input int unsigned w, input int unsigned d);
    int unsigned a, f;
    exp_t e;
    distance_mm = 12'(d);
    @(posedge clk); #1 trig = 1'b1; a = cyc;
    repeat (w) @(posedge clk);
    #1 trig = 1'b0; f = cyc;
    if (a + 2 >= model_idle) begin
      if (w >= MIN_TRIG) begin
        e.is_echo = 1'b1; e.at = f + BURST + 3; e.width = ref_len(d);
        model_idle = e.at + e.width + HOLDOFF;
      end else begin
        e.is_echo = 1'b0; e.at = f + 3; e.width = 0;
        model_idle = f + 3;
      end
      sb.push_back(e);
    end
    repeat (4) @(posedge clk);
    #1 distance_mm = 12'($urandom_range(0, 4095));
  endtask

  function automatic int unsigned pick_d();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return MAXMM;
      3: return MAXMM + 1;
      4: return 4095;
      default: return $urandom_range(1, MAXMM);
    endcase
  endfunction

  // monitor: compares observed events against the head of the scoreboard
  initial begin
    bit echo_p, busy_p, short_p, in_echo, bf_valid;
    int unsigned rise_c, exp_w, bf_exp;
    exp_t e;
    echo_p = 0; busy_p = 0; short_p = 0; in_echo = 0; bf_valid = 0;
    rise_c = 0; exp_w = 0; bf_exp = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        echo_p = 0; busy_p = 0; short_p = 0; in_echo = 0; bf_valid = 0;
        continue;
      end
      if (echo && !echo_p) begin
        if (sb.size() == 0) fail_now("unexpected_echo");
        else begin
          e = sb.pop_front();
          check("echo_kind", e.is_echo, 1);
          check("echo_rise_cycle", cyc, e.at);
          in_echo = 1; rise_c = cyc; exp_w = e.width;
        end
      end
      if (!echo && echo_p && in_echo) begin
        check("echo_width", cyc - rise_c, exp_w);
        in_echo = 0; bf_valid = 1; bf_exp = cyc + HOLDOFF;
      end
      if (short_trig) begin
        check("short_trig_one_cycle", short_p, 0);
        if (!short_p) begin
          if (sb.size() == 0) fail_now("unexpected_short_trig");
          else begin
            e = sb.pop_front();
            check("short_kind", e.is_echo, 0);
            check("short_trig_cycle", cyc, e.at);
            bf_valid = 1; bf_exp = cyc;
          end
        end
      end
      if (!busy && busy_p) begin
        if (bf_valid) check("busy_fall_cycle", cyc, bf_exp);
        else fail_now("unexpected_busy_fall");
        bf_valid = 0;
      end
      echo_p = echo; busy_p = busy; short_p = short_trig;
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d, expected completion earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    rst = 1'b0; trig = 1'b0; distance_mm = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_echo", echo, 0);
    check("reset_busy", busy, 0);
    check("reset_short_trig", short_trig, 0);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    send(20, 100);
    send(20, 0);
    send(25, 4095);
    send(20, MAXMM);
    send(20, MAXMM + 1);
    send(20, 1);
    send(19, 40);
    send(20, 40);

    // retriggers during ECHO and during HOLDOFF must be ignored
    send(20, 80);
    repeat (60) @(posedge clk);
    send(25, 30);
    repeat (160) @(posedge clk);
    send(20, 5);

    // reset in the middle of an echo
    while (cyc < model_idle) @(posedge clk);
    send(20, MAXMM);
    repeat (BURST + 10) @(posedge clk);
    #3;
    check("echo_high_before_reset", echo, 1);
    rst = 1'b0;
    #1;
    check("echo_async_reset", echo, 0);
    check("busy_async_reset", busy, 0);
    sb.delete();
    model_idle = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    send(20, 60);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 400)) @(posedge clk);
      if ($urandom_range(0, 3) == 0) send($urandom_range(1, MIN_TRIG - 1), pick_d());
      else send($urandom_range(MIN_TRIG, MIN_TRIG + 30), pick_d());
    end

    while (cyc < model_idle + 10) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    check("final_echo", echo, 0);
    check("final_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
